booth_mult_r4: RTL and testbench
================================

# booth_mult_r4

Parametrised radix-4 Booth sequential multiplier. It multiplies two `WIDTH`-bit operands, signed or unsigned, selected per operation. Successor to the fixed 12-bit Booth multiplier in the arithmetic datapath, with exact full-width results for both signednesses. Adds a synchronous reset, a one-cycle `done` pulse and a result register that holds its value between operations.

## Interface
- `WIDTH`, default 12: operand width. Must be even and ≥ 4; elaboration error otherwise.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request. Accepted only on an edge where `ready`=1.
- `signed_mode`  in  1: 1 = two's-complement operands, 0 = unsigned. Sampled on the accept edge.
- `multiplicand`  in  `WIDTH`: operand A, sampled on the accept edge.
- `multiplier`  in  `WIDTH`: operand B, sampled on the accept edge.
- `ready`  out  1: idle, can accept `start`.
- `done`  out  1: one-cycle pulse; `prod` is updated in the same cycle.
- `prod`  out  2*`WIDTH`: last completed product. Held until the next `done`.

## Operation
- States:
  - IDLE (`ready`=1).
  - RUN (`ready`=0), with iteration counter `cnt`.
- IDLE→RUN on `start`&&`ready`. On that edge:
  - A and B are extended to `WIDTH`+2 bits: sign-extended if `signed_mode`, zero-extended otherwise.
  - Accumulator ← 0, shift register ← extended B, lost bit ← 0.
  - `cnt` ← N, where N = `WIDTH`/2+1.
- Each RUN edge:
  - Form the Booth digit from {b[1], b[0], lost}: 000/111→0, 001/010→+A, 011→+2A, 100→−2A, 101/110→−A.
  - Add the digit to the upper accumulator, which is `WIDTH`+3 bits wide so ±2A never overflows.
  - lost ← b[1].
  - Arithmetic-shift the {acc, b} pair right by 2 bits.
  - `cnt` decrements by 1.
- On the edge where `cnt` goes 1→0:
  - `prod` ← low 2*`WIDTH` bits of the final {acc, b}. This is the exact product for both modes.
  - `done`=1 for the following cycle; state → IDLE, `ready`=1.
- `start` while `ready`=0: ignored. It is not queued and operands are not sampled.
- `signed_mode` or operand changes during RUN have no effect.
- Unsigned mode: the extra zero bits make the top digit non-negative, so no correction term is needed.

## Timing
- Reset values: `ready`=1, `done`=0, `prod`=0, `cnt`=0, accumulator=0. `rst` overrides `start` on the same edge.
- Latency: accept on edge k; `done`=1 and new `prod` after edge k+N. For `WIDTH`=12, N=7.
- `ready` is 0 after edge k through edge k+N−1 and returns to 1 together with `done`.
- Back-to-back: `start`=1 in the `done` cycle is accepted. Throughput is one product per N cycles, with no idle bubble.
- Reset mid-RUN: the operation is aborted with no `done` pulse, and `prod` is cleared to 0.
- `prod` stays stable at all times other than a `done` update or a reset.

## Structure
- Package `booth_pkg` holds:
  - `booth_digit_t` enum: ZERO, P1, P2, M1, M2.
  - `booth_decode()` function: 3-bit window → digit.
  - Localparam helper for N = `WIDTH`/2+1.
- Sub-module `booth_r4_recoder`: combinational. Takes the 3-bit window and extended A; outputs the `WIDTH`+3-bit addend, with the sign already applied.
- The top level holds the FSM/counter, the accumulator/shift register, and the `prod` output register.

## Test plan
- `WIDTH`=12, signed: A=−2048 (0x800), B=−2048 → `prod`=0x400000 exactly 7 cycles after accept; one `done` pulse.
- `WIDTH`=12, unsigned: 0xFFF × 0xFFF → `prod`=0xFFE001. Same operand bits with `signed_mode`=1 → `prod`=0x000001.
- Signed: A=−1 (0xFFF), B=1 → `prod`=0xFFFFFF. A=5, B=−3 → `prod`=0xFFFFF1.
- During RUN, pulse `start` with A=B=0x7FF → ignored; result is that of the first operands; `ready` stays 0 until `done`.
- Assert `rst` at cycle 3 of RUN → next cycle `ready`=1, `done`=0, `prod`=0; no `done` follows.
- Issue 3 back-to-back starts, each in the previous `done` cycle → 3 `done` pulses spaced exactly 7 cycles apart, each with the correct product. Repeat for `WIDTH`=4 (N=3) and `WIDTH`=16 (N=9) with exhaustive or random compare against a reference model.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
// Digit decoding lives here so the recoder and any checker agree.
package booth_pkg;

  typedef enum logic [2:0] {
    ZERO,
    P1,
    P2,
    M1,
    M2
  } booth_digit_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Iterations needed to consume a WIDTH+2 bit extended multiplier.
  function automatic int booth_iters(input int width);
    return width / 2 + 1;
  endfunction

  function automatic booth_digit_t booth_decode(input logic [2:0] window);
    booth_digit_t d;
    d = ZERO;
    case (window)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit window onto a signed addend
// of WIDTH+3 bits so that +/-2A always fits.
module booth_r4_recoder
  import booth_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [2:0]       window,
  input  logic [WIDTH+1:0] a_ext,
  output logic [WIDTH+2:0] addend
);

  booth_digit_t     digit;
  logic [WIDTH+2:0] a1;
  logic [WIDTH+2:0] a2;

  assign digit = booth_decode(window);
  assign a1    = {a_ext[WIDTH+1], a_ext};
  assign a2    = {a_ext, 1'b0};

  always_comb begin
    addend = '0;
    unique case (1'b1)
      digit == P1: addend = a1;
      digit == P2: addend = a2;
      digit == M1: addend = -a1;
      digit == M2: addend = -a2;
      default:     addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_r4.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per op.
// One product every WIDTH/2+1 cycles; prod holds between ops.
module booth_mult_r4
  import booth_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int N  = booth_iters(WIDTH);
  localparam int CW = $clog2(N + 1);
  localparam int XW = WIDTH + 2;
  localparam int AW = WIDTH + 3;

  if (WIDTH % 2 != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_mult_r4: WIDTH must be even and >= 4");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;
  logic [XW-1:0]    a_ext;
  logic [XW-1:0]    b_sh;
  logic             lost;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    sum;
  logic [AW+XW-1:0] pair;
  logic [XW-1:0]    a_in;
  logic [XW-1:0]    b_in;

  booth_r4_recoder #(
    .WIDTH(WIDTH)
  ) u_rec (
    .window({b_sh[1:0], lost}),
    .a_ext (a_ext),
    .addend(addend)
  );

  assign sum  = acc + addend;
  assign pair = $signed({sum, b_sh}) >>> 2;

  // Zero extension keeps the top digit non-negative in unsigned mode.
  assign a_in = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                            : {2'b00, multiplicand};
  assign b_in = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                            : {2'b00, multiplier};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      prod  <= '0;
      cnt   <= '0;
      acc   <= '0;
      a_ext <= '0;
      b_sh  <= '0;
      lost  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            ready <= 1'b0;
            a_ext <= a_in;
            b_sh  <= b_in;
            acc   <= '0;
            lost  <= 1'b0;
            cnt   <= CW'(N);
          end
        end
        RUN: begin
          acc  <= pair[AW+XW-1 -: AW];
          b_sh <= pair[XW-1:0];
          lost <= b_sh[1];
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            prod  <= pair[2*WIDTH-1:0];
            done  <= 1'b1;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_r4.sv
// Scoreboard bench for booth_mult_r4 at WIDTH 12, plus 4 and 16.
// Expected products come from plain integer multiplication.
module tb_booth_mult_r4;

  localparam int W = 12;
  localparam int N = W / 2 + 1;
  localparam int SW [2] = '{4, 16};

  typedef struct {
    logic [63:0] p;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected event expected none (cycle %0d)",
             name, cyc);
  endtask

  function automatic logic [63:0] ref_mul(input int w, input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic sm);
    logic [63:0] m;
    logic [63:0] p;
    longint sa;
    longint sb;
    m = (64'd1 << w) - 64'd1;
    a = a & m;
    b = b & m;
    if (sm) begin
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
      p  = 64'(sa * sb);
    end else begin
      p = a * b;
    end
    return p & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Main instance, WIDTH=12
  logic           rst;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           ready;
  logic           done;
  logic [2*W-1:0] prod;

  booth_mult_r4 #(.WIDTH(W)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .ready       (ready),
    .done        (done),
    .prod        (prod)
  );

  exp_t        q[$];
  logic [63:0] held = '0;
  bit          mon_en = 1'b0;
  bit          sub_fin [2];

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk("ready", 64'(ready), 64'((q.size() == 0) || (done === 1'b1)));
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          fail("unexpected_done");
        end else begin
          e = q.pop_front();
          chk("prod", 64'(prod), e.p);
          chk("done_cycle", 64'(cyc), 64'(e.due));
          held = e.p;
        end
      end else begin
        if (q.size() > 0 && q[0].due <= cyc) begin
          fail("missing_done");
          void'(q.pop_front());
        end
        chk("prod_hold", 64'(prod), held);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sm, input logic [63:0] exp);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (ready !== 1'b1) begin
      fail("issue_wait");
      return;
    end
    start        = 1'b1;
    signed_mode  = sm;
    multiplicand = a;
    multiplier   = b;
    @(posedge clk);
    #1;
    q.push_back('{p: exp, due: cyc + N});
    start        = 1'b0;
    signed_mode  = 1'($urandom);
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
  endtask

  task automatic issue_rand();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sm;
    a  = W'($urandom);
    b  = W'($urandom);
    sm = 1'($urandom);
    issue(a, b, sm, ref_mul(W, 64'(a), 64'(b), sm));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) fail("wait_idle");
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_prod", 64'(prod), 64'd0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    issue(12'h800, 12'h800, 1'b1, 64'h400000);
    issue(12'hFFF, 12'hFFF, 1'b0, 64'hFFE001);
    issue(12'hFFF, 12'hFFF, 1'b1, 64'h000001);
    issue(12'hFFF, 12'h001, 1'b1, 64'hFFFFFF);
    issue(12'h005, 12'hFFD, 1'b1, 64'hFFFFF1);
    wait_idle();

    repeat (3) issue_rand();
    wait_idle();

    // starts during RUN must be ignored
    issue(12'h003, 12'h004, 1'b0, 64'd12);
    repeat (2) begin
      start = 1'b1;
      signed_mode = 1'b1;
      multiplicand = 12'h7FF;
      multiplier = 12'h7FF;
      @(posedge clk);
      #1;
      chk("busy_ready", 64'(ready), 64'd0);
    end
    start = 1'b0;
    wait_idle();

    // reset applied on the third RUN edge aborts the op
    issue(12'h123, 12'h456, 1'b1, ref_mul(W, 64'h123, 64'h456, 1'b1));
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    held = '0;
    @(negedge clk);
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_prod", 64'(prod), 64'd0);
    repeat (12) @(posedge clk);
    #1;

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      issue_rand();
    end
    wait_idle();

    n = 0;
    while (!(sub_fin[0] && sub_fin[1]) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!(sub_fin[0] && sub_fin[1])) fail("sub_timeout");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Extra widths: WIDTH=4 exhaustive, WIDTH=16 random, back-to-back
  for (genvar g = 0; g < 2; g++) begin : g_sub
    localparam int SWD = SW[g];
    localparam int SN  = SWD / 2 + 1;

    logic             s_rst;
    logic             s_start;
    logic             s_sm;
    logic [SWD-1:0]   s_a;
    logic [SWD-1:0]   s_b;
    logic             s_ready;
    logic             s_done;
    logic [2*SWD-1:0] s_prod;
    logic [63:0]      s_held;
    bit               s_en;
    exp_t             sq[$];

    booth_mult_r4 #(.WIDTH(SWD)) u_dut (
      .clk         (clk),
      .rst         (s_rst),
      .start       (s_start),
      .signed_mode (s_sm),
      .multiplicand(s_a),
      .multiplier  (s_b),
      .ready       (s_ready),
      .done        (s_done),
      .prod        (s_prod)
    );

    always @(negedge clk) begin
      if (s_en) begin
        exp_t e;
        chk($sformatf("w%0d_ready", SWD), 64'(s_ready),
            64'((sq.size() == 0) || (s_done === 1'b1)));
        if (s_done === 1'b1) begin
          if (sq.size() == 0) begin
            fail($sformatf("w%0d_unexpected_done", SWD));
          end else begin
            e = sq.pop_front();
            chk($sformatf("w%0d_prod", SWD), 64'(s_prod), e.p);
            chk($sformatf("w%0d_done_cycle", SWD), 64'(cyc), 64'(e.due));
            s_held = e.p;
          end
        end else begin
          if (sq.size() > 0 && sq[0].due <= cyc) begin
            fail($sformatf("w%0d_missing_done", SWD));
            void'(sq.pop_front());
          end
          chk($sformatf("w%0d_prod_hold", SWD), 64'(s_prod), s_held);
        end
      end
    end

    initial begin
      int ops;
      int n;
      logic [SWD-1:0] a;
      logic [SWD-1:0] b;
      logic sm;
      s_en = 1'b0;
      s_rst = 1'b1;
      s_start = 1'b0;
      s_sm = 1'b0;
      s_a = '0;
      s_b = '0;
      s_held = '0;
      ops = (SWD == 4) ? 512 : 200;
      repeat (2) @(posedge clk);
      #1;
      s_rst = 1'b0;
      s_en = 1'b1;
      for (int i = 0; i < ops; i++) begin
        if (SWD == 4) begin
          a  = SWD'(i & 15);
          b  = SWD'((i >> 4) & 15);
          sm = i[8];
        end else begin
          a  = SWD'($urandom);
          b  = SWD'($urandom);
          sm = 1'($urandom);
        end
        n = 0;
        while (s_ready !== 1'b1 && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        if (s_ready !== 1'b1) begin
          fail($sformatf("w%0d_issue_wait", SWD));
          break;
        end
        s_start = 1'b1;
        s_sm = sm;
        s_a = a;
        s_b = b;
        @(posedge clk);
        #1;
        sq.push_back('{p: ref_mul(SWD, 64'(a), 64'(b), sm), due: cyc + SN});
        s_start = 1'b0;
        s_sm = 1'($urandom);
        s_a = SWD'($urandom);
        s_b = SWD'($urandom);
      end
      n = 0;
      while (sq.size() != 0 && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (sq.size() != 0) fail($sformatf("w%0d_drain", SWD));
      sub_fin[g] = 1'b1;
    end
  end

endmodule
